coproc_result_queue: RTL

COPROC_RESULT_QUEUE -- requirements
Module: coproc_result_queue

---
 rtl/coproc_result_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/coproc_result_queue.sv
// -----------------------------------------------------------------------------
// coproc_result_queue
//
// Holds results coming back from an offloaded coprocessor instruction until
// the core has decided (commit or kill) what to do with the matching id.
// Results leave in push order. A committed head is offered on the result port.
// A killed head is dropped silently. Commits may arrive before or after the
// result they refer to and are kept in a per-id table.
//
// Parameters
//   DEPTH  number of result entries (power of two, 2..8)
//   ID_W   width of the offload instruction id
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   ex_valid_i/ex_ready_o  result handshake from the execute stage
//   ex_id_i, ex_rd_i,      result id, destination register, data and
//   ex_data_i, ex_we_i     write enable
//   commit_valid_i,        core decision for an offloaded id
//   commit_id_i,           (commit_kill_i = 1 means discard)
//   commit_kill_i
//   result_valid_o/        result handshake towards the core
//   result_ready_i
//   result_id_o, result_rd_o,
//   result_data_o,         head entry fields (zero while the queue is empty)
//   result_we_o
// -----------------------------------------------------------------------------
module coproc_result_queue #(
   parameter int DEPTH = 4,
   parameter int ID_W  = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            ex_valid_i,
   output logic            ex_ready_o,
   input  logic [ID_W-1:0] ex_id_i,
   input  logic [4:0]      ex_rd_i,
   input  logic [31:0]     ex_data_i,
   input  logic            ex_we_i,

   input  logic            commit_valid_i,
   input  logic [ID_W-1:0] commit_id_i,
   input  logic            commit_kill_i,

   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [ID_W-1:0] result_id_o,
   output logic [4:0]      result_rd_o,
   output logic [31:0]     result_data_o,
   output logic            result_we_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int NID   = 1 << ID_W;

   // entry storage (data path, not reset; gated by r_count on the outputs)
   logic [ID_W-1:0] r_id_mem   [DEPTH];
   logic [4:0]      r_rd_mem   [DEPTH];
   logic [31:0]     r_data_mem [DEPTH];
   logic            r_we_mem   [DEPTH];

   // control state
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [NID-1:0]   r_cmt;
   logic [NID-1:0]   r_kill;

   logic            w_nonempty;
   logic            w_full;
   logic [ID_W-1:0] w_head_id;
   logic            w_head_cmt;
   logic            w_head_kill;
   logic            w_push;
   logic            w_pop_ok;
   logic            w_pop_kill;
   logic            w_pop;
   logic            w_cmt_wr;

   assign w_nonempty  = (r_count != '0);
   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_head_id   = r_id_mem[r_rd_ptr];
   assign w_head_cmt  = r_cmt[w_head_id];
   assign w_head_kill = r_kill[w_head_id];

   // Full blocks the push even when a pop frees a slot in the same cycle,
   // keeping ex_ready_o a pure function of state.
   assign ex_ready_o = !w_full;
   assign w_push     = ex_valid_i && !w_full;

   assign result_valid_o = w_nonempty && w_head_cmt && !w_head_kill;
   assign w_pop_ok       = result_valid_o && result_ready_i;
   assign w_pop_kill     = w_nonempty && w_head_cmt && w_head_kill;
   assign w_pop          = w_pop_ok || w_pop_kill;

   // First commit wins; a commit aimed at the id being popped this cycle is
   // dropped so the freed table slot starts clean for the next use of the id.
   assign w_cmt_wr = commit_valid_i && !r_cmt[commit_id_i] &&
                     !(w_pop && (commit_id_i == w_head_id));

   assign result_id_o   = w_nonempty ? w_head_id            : '0;
   assign result_rd_o   = w_nonempty ? r_rd_mem[r_rd_ptr]   : '0;
   assign result_data_o = w_nonempty ? r_data_mem[r_rd_ptr] : '0;
   assign result_we_o   = w_nonempty ? r_we_mem[r_rd_ptr]   : 1'b0;

   // --- entry write ---
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_id_mem[r_wr_ptr]   <= ex_id_i;
         r_rd_mem[r_wr_ptr]   <= ex_rd_i;
         r_data_mem[r_wr_ptr] <= ex_data_i;
         r_we_mem[r_wr_ptr]   <= ex_we_i;
      end
   end

   // --- pointers and occupancy ---
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // --- commit table ---
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cmt  <= '0;
         r_kill <= '0;
      end else begin
         if (w_cmt_wr) begin
            r_cmt[commit_id_i]  <= 1'b1;
            r_kill[commit_id_i] <= commit_kill_i;
         end
         if (w_pop) begin
            r_cmt[w_head_id]  <= 1'b0;
            r_kill[w_head_id] <= 1'b0;
         end
      end
   end

endmodule
